// File: rtl/rob_commit_ctrl.sv
// rob_commit_ctrl
//
// Commit scheduler sitting between the ROB head and the architectural
// regfile, the LSQ and the fetch redirect logic. Each cycle it looks at
// the COMMIT_W oldest ROB entries and retires an in-order prefix of them.
// Stores are retired one at a time through an LSQ request/ack handshake.
// A retiring mispredicted control-flow entry triggers a one-cycle flush.
//
// Optional feature macro: COMMIT_PERF_CNT_EN
//   When defined, adds perf_retired, perf_flushes and perf_store_stall
//   32-bit counter outputs.
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   head_tag         ROB tag of window slot 0 (oldest)
//   win_valid/rdy    per-slot occupied / result ready
//   win_is_store     per-slot store marker
//   win_mispred      per-slot resolved mispredicted br/jal/jalr
//   win_rd/data      per-slot destination register and result
//   win_target       per-slot correct next PC
//   st_req/st_tag    store request to the LSQ and the store's ROB tag
//   st_ack           LSQ has performed the requested store
//   num_deq          number of entries retired this cycle (combinational)
//   rf_we/rd/data    regfile write port per slot
//   flush_valid      one-cycle pipeline flush pulse
//   flush_pc         redirect PC
//   flush_front_tag  ROB front after the flush
module rob_commit_ctrl #(
   parameter int width    = 32,
   parameter int size     = 8,
   parameter int COMMIT_W = 4,
   parameter int TAG_W    = $clog2(size)
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [TAG_W-1:0]                   head_tag,
   input  logic [COMMIT_W-1:0]                win_valid,
   input  logic [COMMIT_W-1:0]                win_rdy,
   input  logic [COMMIT_W-1:0]                win_is_store,
   input  logic [COMMIT_W-1:0]                win_mispred,
   input  logic [COMMIT_W-1:0][4:0]           win_rd,
   input  logic [COMMIT_W-1:0][width-1:0]     win_data,
   input  logic [COMMIT_W-1:0][width-1:0]     win_target,
   output logic                               st_req,
   output logic [TAG_W-1:0]                   st_tag,
   input  logic                               st_ack,
   output logic [$clog2(COMMIT_W+1)-1:0]      num_deq,
   output logic [COMMIT_W-1:0]                rf_we,
   output logic [COMMIT_W-1:0][4:0]           rf_rd,
   output logic [COMMIT_W-1:0][width-1:0]     rf_data,
   output logic                               flush_valid,
   output logic [width-1:0]                   flush_pc,
`ifdef COMMIT_PERF_CNT_EN
   output logic [31:0]                        perf_retired,
   output logic [31:0]                        perf_flushes,
   output logic [31:0]                        perf_store_stall,
`endif
   output logic [TAG_W-1:0]                   flush_front_tag
);

   localparam int NDQ_W = $clog2(COMMIT_W+1);

   typedef enum logic [1:0] {RUN, STORE_WAIT, FLUSH} state_t;
   state_t state;

   logic [NDQ_W-1:0] run_cnt;
   logic             mp_hit;
   logic [width-1:0] mp_target;
   logic             scan_stop;
   logic             store_head;
   logic [TAG_W:0]   tag_sum;
   logic [TAG_W-1:0] front_tag;

   // In-order scan: retire the leading run of ready non-store slots, cutting
   // the run just after the first mispredicted one. A store (even if it is
   // also flagged mispredicted) stops the scan and is never counted here.
   always_comb begin
      run_cnt   = '0;
      mp_hit    = 1'b0;
      mp_target = '0;
      scan_stop = 1'b0;
      for (int i = 0; i < COMMIT_W; i++) begin
         if (!scan_stop) begin
            if (win_valid[i] && win_rdy[i] && !win_is_store[i]) begin
               run_cnt = NDQ_W'(i + 1);
               if (win_mispred[i]) begin
                  mp_hit    = 1'b1;
                  mp_target = win_target[i];
                  scan_stop = 1'b1;
               end
            end else begin
               scan_stop = 1'b1;
            end
         end
      end
   end

   // Slot 0 being a ready store implies run_cnt == 0 and no mispredict.
   assign store_head = win_valid[0] && win_rdy[0] && win_is_store[0];

   // New ROB front is one past the mispredicted slot, i.e. head_tag + run_cnt,
   // wrapped modulo size (size need not be a power of two).
   assign tag_sum   = (TAG_W+1)'(head_tag) + (TAG_W+1)'(run_cnt);
   assign front_tag = (tag_sum >= (TAG_W+1)'(size)) ? TAG_W'(tag_sum - (TAG_W+1)'(size))
                                                    : TAG_W'(tag_sum);

   always_comb begin
      num_deq = '0;
      case (state)
         RUN:        num_deq = run_cnt;
         STORE_WAIT: num_deq = st_ack ? NDQ_W'(1) : '0;
         default:    num_deq = '0;
      endcase
   end

   // A retiring store never writes the regfile, so the store-ack cycle
   // forces all enables low regardless of the window contents.
   always_comb begin
      rf_we = '0;
      if (state == RUN) begin
         for (int i = 0; i < COMMIT_W; i++) begin
            rf_we[i] = (NDQ_W'(i) < num_deq) && (win_rd[i] != 5'd0) && !win_is_store[i];
         end
      end
   end

   assign rf_rd   = win_rd;
   assign rf_data = win_data;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= RUN;
         st_req          <= 1'b0;
         st_tag          <= '0;
         flush_valid     <= 1'b0;
         flush_pc        <= '0;
         flush_front_tag <= '0;
      end else begin
         flush_valid <= 1'b0;
         case (state)
            RUN: begin
               if (mp_hit) begin
                  state           <= FLUSH;
                  flush_valid     <= 1'b1;
                  flush_pc        <= mp_target;
                  flush_front_tag <= front_tag;
               end else if (store_head) begin
                  state  <= STORE_WAIT;
                  st_req <= 1'b1;
                  st_tag <= head_tag;
               end
            end
            STORE_WAIT: begin
               if (st_ack) begin
                  state  <= RUN;
                  st_req <= 1'b0;
               end
            end
            FLUSH:   state <= RUN;
            default: state <= RUN;
         endcase
      end
   end

`ifdef COMMIT_PERF_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_retired     <= '0;
         perf_flushes     <= '0;
         perf_store_stall <= '0;
      end else begin
         perf_retired <= perf_retired + 32'(num_deq);
         if (flush_valid) perf_flushes <= perf_flushes + 32'd1;
         if (state == STORE_WAIT && !st_ack) perf_store_stall <= perf_store_stall + 32'd1;
      end
   end
`endif

endmodule
